// File: rtl/multiplicador_pkg.sv
// rtl/multiplicador_pkg.sv - shared state type, default width and counter sizing for the sequential multiplier
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_DEFAULT_N = 4;

    // The iteration counter must hold the value N itself, not just N-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sumador_n.sv
// rtl/sumador_n.sv - parameterised N-bit ripple-carry adder built from chained full-adder cells
module sumador_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cen,
    output logic [N-1:0] s,
    output logic         csal
);

    logic [N:0] c;

    assign c[0] = cen;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign csal = c[N];

endmodule

// File: rtl/multiplicador_seq.sv
// rtl/multiplicador_seq.sv - shift-and-add unsigned multiplier, one partial product per clock
// Optional build macro: MULTIPLICADOR_ZERO_BYPASS_EN (zero operand finishes in one cycle).
module multiplicador_seq
    import multiplicador_pkg::*;
#(
    parameter int N = MULT_DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [2*N-1:0] pr_q, pr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] p_q, p_d;

    logic [N-1:0]   add_b;
    logic [N-1:0]   add_s;
    logic           add_c;
    logic [2*N-1:0] pr_shift;
    logic           zero_op;

    assign add_b = pr_q[0] ? a_q : '0;

    sumador_n #(
        .N (N)
    ) u_sumador (
        .a    (pr_q[2*N-1:N]),
        .b    (add_b),
        .cen  (1'b0),
        .s    (add_s),
        .csal (add_c)
    );

    // The bit above the product is always zero after the shift, so it is not stored.
    assign pr_shift = {add_c, add_s, pr_q[N-1:1]};

`ifdef MULTIPLICADOR_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_op) begin
                        state_d = DONE;
                        p_d     = '0;
                    end else begin
                        state_d = RUN;
                        a_d     = a;
                        pr_d    = {{N{1'b0}}, b};
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            RUN: begin
                pr_d  = pr_shift;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    p_d     = pr_shift;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// tb/tb_multiplicador_seq.sv - self-checking bench for multiplicador_seq (N=4 and N=8 instances)
module tb_multiplicador_seq;

`ifdef MULTIPLICADOR_ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  a     = '0;
    logic [3:0]  b     = '0;
    logic        busy, done;
    logic [7:0]  p;

    logic        start8 = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    multiplicador_seq #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    multiplicador_seq #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic issue(input logic [3:0] aa, input logic [3:0] bb);
        start = 1'b1;
        a     = aa;
        b     = bb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle index (start cycle = 0) at which done is seen, or -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (p !== 8'd0) begin failures++; $display("FAIL reset_p got=%0d exp=0", p); end
        checks++; if (p8 !== 16'd0 || busy8 !== 1'b0) begin failures++; $display("FAIL reset_n8 got p=%0d busy=%b exp p=0 busy=0", p8, busy8); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done); end
    endtask

    task automatic test_basic();
        int lat;
        int unsigned exp;
        exp_q.push_back(32'd225);
        issue(4'd15, 4'd15);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%b exp=0", done); end
        wait_done(lat);
        exp = exp_q.pop_front();
        checks++; if (lat != 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (p !== 8'(exp)) begin failures++; $display("FAIL basic_p got=%0d exp=%0d", p, exp); end
        repeat (3) @(negedge clk);
        checks++; if (p !== 8'(exp)) begin failures++; $display("FAIL basic_p_hold got=%0d exp=%0d", p, exp); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_idle got busy=%b done=%b exp 0 0", busy, done); end
    endtask

    task automatic test_seq();
        int lat;
        int unsigned exp;
        exp_q.push_back(32'd143);
        issue(4'd13, 4'd11);
        wait_done(lat);
        exp = exp_q.pop_front();
        checks++; if (lat != 5) begin failures++; $display("FAIL seq1_latency got=%0d exp=5", lat); end
        checks++; if (p !== 8'(exp)) begin failures++; $display("FAIL seq1_p got=%0d exp=%0d", p, exp); end
        @(negedge clk);
        exp_q.push_back(32'd0);
        issue(4'd1, 4'd0);
        wait_done(lat);
        exp = exp_q.pop_front();
        checks++; if (lat != (ZB ? 1 : 5)) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, ZB ? 1 : 5); end
        checks++; if (p !== 8'(exp)) begin failures++; $display("FAIL zero_p got=%0d exp=%0d", p, exp); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int snap;
        int unsigned exp;
        repeat (2) @(negedge clk);
        snap = done_cnt;
        exp_q.push_back(32'd42);
        issue(4'd6, 4'd7);
        a = 4'd2;
        b = 4'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ignore_done_c5 got=%b exp=1", done); end
        checks++; if (p !== 8'(exp)) begin failures++; $display("FAIL ignore_p got=%0d exp=%0d", p, exp); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ignore_done_start got busy=%b done=%b exp 0 0", busy, done); end
        repeat (8) @(negedge clk);
        checks++; if (done_cnt - snap != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt - snap); end
        checks++; if (p !== 8'(exp)) begin failures++; $display("FAIL ignore_p_hold got=%0d exp=%0d", p, exp); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int snap;
        int unsigned exp;
        snap = done_cnt;
        issue(4'd9, 4'd9);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_state got busy=%b done=%b exp 0 0", busy, done); end
        checks++; if (p !== 8'd0) begin failures++; $display("FAIL abort_p got=%0d exp=0", p); end
        repeat (8) @(negedge clk);
        checks++; if (done_cnt != snap) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - snap); end
        exp_q.push_back(32'd15);
        issue(4'd3, 4'd5);
        wait_done(lat);
        exp = exp_q.pop_front();
        checks++; if (lat != 5) begin failures++; $display("FAIL after_abort_latency got=%0d exp=5", lat); end
        checks++; if (p !== 8'(exp)) begin failures++; $display("FAIL after_abort_p got=%0d exp=%0d", p, exp); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int snap;
        int bad;
        snap = done_cnt;
        bad  = 0;
        for (int i = 0; i < 256; i++) begin
            logic [3:0]  ta;
            logic [3:0]  tb;
            logic [7:0]  got;
            int          seen;
            int          lat_seen;
            int          lat_exp;
            int unsigned exp;
            ta       = 4'(i >> 4);
            tb       = 4'(i);
            seen     = 0;
            lat_seen = -1;
            got      = '0;
            lat_exp  = (ZB && (ta == 4'd0 || tb == 4'd0)) ? 1 : 5;
            exp_q.push_back(32'(ta) * 32'(tb));
            start = 1'b1;
            a     = ta;
            b     = tb;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (done === 1'b1) begin
                    seen++;
                    lat_seen = c;
                    got      = p;
                end
            end
            exp = exp_q.pop_front();
            checks++;
            if (seen != 1 || lat_seen != lat_exp || got !== 8'(exp)) begin
                failures++;
                bad++;
                if (bad <= 8)
                    $display("FAIL sweep_%0dx%0d got p=%0d dones=%0d lat=%0d exp p=%0d dones=1 lat=%0d",
                             ta, tb, got, seen, lat_seen, exp, lat_exp);
            end
        end
        checks++; if (done_cnt - snap != 256) begin failures++; $display("FAIL sweep_done_total got=%0d exp=256", done_cnt - snap); end
    endtask

    task automatic test_n8();
        int lat;
        int unsigned exp;
        exp_q.push_back(32'd65025);
        start8 = 1'b1;
        a8     = 8'd255;
        b8     = 8'd255;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'd0;
        b8     = 8'd0;
        checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL n8_busy got=%b exp=1", busy8); end
        lat = 1;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done8 !== 1'b1) lat = -1;
        exp = exp_q.pop_front();
        checks++; if (lat != 9) begin failures++; $display("FAIL n8_latency got=%0d exp=9", lat); end
        checks++; if (p8 !== 16'(exp)) begin failures++; $display("FAIL n8_p got=%0d exp=%0d", p8, exp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_n8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
